// File: rtl/esp_uart_tx_fifo.sv
// Purpose: in-order transmit buffer of bytes and break requests feeding esp_uart_tx.
// Latency: an entry written to an empty, idle block is strobed out two edges after the write.
// Backpressure: a write to a full FIFO is dropped (sets sticky overflow) unless a pop happens the same cycle;
//               entries are issued only while tx_busy is low.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   wr_data/wr_en/wr_break    enqueue a byte, or a break entry (break has priority)
//   overflow_clr              clears the sticky overflow flag
//   fifo_count/empty/full     fill level status
//   overflow                  sticky: a write was dropped
//   idle                      nothing queued, nothing being issued, transmitter not busy
//   tx_data/tx_valid/tx_break one-cycle start strobes towards esp_uart_tx
//   tx_busy                   transmitter busy indication from esp_uart_tx
module esp_uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    input  logic                  wr_break,
    input  logic                  overflow_clr,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic                  idle,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  tx_break,
    input  logic                  tx_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    // Entry format: bit 8 = break marker, bits 7:0 = data byte.
    logic [8:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [1:0]            state;

    logic       wr_req;
    logic       pop;
    logic       wr_accept;
    logic       wr_drop;
    logic [8:0] wr_entry;
    logic [8:0] head;

    assign head       = mem[rd_ptr];
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign idle       = fifo_empty && (state == S_IDLE) && !tx_busy;

    assign wr_req   = wr_en | wr_break;
    assign wr_entry = wr_break ? 9'h100 : {1'b0, wr_data};
    assign pop      = (state == S_IDLE) && !fifo_empty && !tx_busy;
    // When full, the slot being popped this cycle is the one written: the head
    // is read combinationally before the edge, so reusing it is safe.
    assign wr_accept = wr_req && (!fifo_full || pop);
    assign wr_drop   = wr_req && !wr_accept;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            state      <= S_IDLE;
            tx_valid   <= 1'b0;
            tx_break   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({wr_accept, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            // A drop in the same cycle as a clear keeps the flag set.
            if (wr_drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end

            // Strobes default low so they last exactly the ISSUE cycle.
            tx_valid <= 1'b0;
            tx_break <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_valid <= !head[8];
                        tx_break <= head[8];
                        tx_data  <= head[8] ? 8'h00 : head[7:0];
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_HOLD;
                // tx_busy is not yet valid for this transfer; skip one cycle.
                S_HOLD:  state <= S_WAIT;
                S_WAIT: begin
                    if (!tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_esp_uart_tx_fifo.sv
module tb_esp_uart_tx_fifo;

    localparam int BUSY_LEN = 6;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       wr_break;
    logic       overflow_clr;
    logic [5:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;
    logic       idle;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_break;
    logic       tx_busy;

    logic       force_busy;
    logic       model_busy;
    int         busy_cnt;

    int tests;
    int fails;

    // Expected strobes, {break, data} in issue order.
    logic [8:0] sb[$];
    logic       prev_strobe;

    esp_uart_tx_fifo #(.DEPTH_LOG2(5)) dut (
        .clk(clk),
        .rst(rst),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .wr_break(wr_break),
        .overflow_clr(overflow_clr),
        .fifo_count(fifo_count),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .overflow(overflow),
        .idle(idle),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_break(tx_break),
        .tx_busy(tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign tx_busy = force_busy | model_busy;

    // Simple transmitter model: samples the strobe on an edge, raises busy
    // one edge later and keeps it for BUSY_LEN cycles.
    initial begin
        busy_cnt   = 0;
        model_busy = 1'b0;
        forever begin
            logic s;
            @(posedge clk);
            s = tx_valid | tx_break;
            #1;
            if (rst) busy_cnt = 0;
            else if (s) busy_cnt = BUSY_LEN + 1;
            else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
            model_busy = (busy_cnt > 0) && (busy_cnt <= BUSY_LEN);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (tx_valid || tx_break)) begin
            check("strobe_exclusive", {31'd0, tx_valid && tx_break}, 32'd0);
            check("strobe_not_back_to_back", {31'd0, prev_strobe}, 32'd0);
            check("strobe_while_busy", {31'd0, tx_busy}, 32'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got brk=%0d data=%0h expected none", tx_break, tx_data);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                check("strobe_entry", {23'd0, tx_break, tx_data}, {23'd0, e});
                check("strobe_valid", {31'd0, tx_valid}, {31'd0, !e[8]});
            end
        end
        prev_strobe = tx_valid | tx_break;
    end

    // One write spanning a single rising edge; returns at the following negedge.
    task automatic do_write(input logic en, input logic brk, input logic [7:0] d);
        wr_en    = en;
        wr_break = brk;
        wr_data  = d;
        @(negedge clk);
        wr_en    = 1'b0;
        wr_break = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n;
        n = 0;
        while (!(idle && sb.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, idle && sb.size() == 0}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests        = 0;
        fails        = 0;
        prev_strobe  = 1'b0;
        force_busy   = 1'b0;
        wr_data      = 8'h00;
        wr_en        = 1'b0;
        wr_break     = 1'b0;
        overflow_clr = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_empty", {31'd0, fifo_empty}, 32'd1);
        check("rst_full", {31'd0, fifo_full}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_strobes", {30'd0, tx_valid, tx_break}, 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: strobe two edges after the write.
        sb.push_back(9'h0A5);
        do_write(1'b1, 1'b0, 8'hA5);
        check("single_count1", 32'(fifo_count), 32'd1);
        check("single_idle_low", {31'd0, idle}, 32'd0);
        check("single_no_early", {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        check("single_valid", {31'd0, tx_valid}, 32'd1);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_count0", 32'(fifo_count), 32'd0);
        @(negedge clk);
        check("single_valid_drop", {31'd0, tx_valid}, 32'd0);
        wait_drained("single_idle_return", 100);

        // Burst of three with the transmitter held busy so the level reaches 3.
        force_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            sb.push_back({1'b0, 8'(i)});
            do_write(1'b1, 1'b0, 8'(i));
        end
        check("burst_peak", 32'(fifo_count), 32'd3);
        force_busy = 1'b0;
        wait_drained("burst_drain", 200);

        // Break ordering; the last write has both enables, break wins.
        sb.push_back(9'h011);
        sb.push_back(9'h100);
        sb.push_back(9'h100);
        do_write(1'b1, 1'b0, 8'h11);
        do_write(1'b0, 1'b1, 8'h99);
        do_write(1'b1, 1'b1, 8'h22);
        wait_drained("break_drain", 200);

        // Overflow while the transmitter is held busy.
        force_busy = 1'b1;
        for (int i = 0; i < 32; i++) begin
            sb.push_back({1'b0, 8'(8'h40 + i)});
            do_write(1'b1, 1'b0, 8'(8'h40 + i));
        end
        check("ovf_full", {31'd0, fifo_full}, 32'd1);
        check("ovf_count32", 32'(fifo_count), 32'd32);
        check("ovf_not_yet", {31'd0, overflow}, 32'd0);
        do_write(1'b1, 1'b0, 8'hEE);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_count_hold", 32'(fifo_count), 32'd32);
        overflow_clr = 1'b1;
        do_write(1'b1, 1'b0, 8'hEF);
        overflow_clr = 1'b0;
        check("ovf_set_wins", {31'd0, overflow}, 32'd1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full with simultaneous pop: the write is accepted.
        force_busy = 1'b0;
        sb.push_back(9'h07E);
        do_write(1'b1, 1'b0, 8'h7E);
        check("fullpop_count", 32'(fifo_count), 32'd32);
        check("fullpop_overflow", {31'd0, overflow}, 32'd0);
        wait_drained("fullpop_drain", 2000);

        // Reset mid-operation with five entries queued.
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) do_write(1'b1, 1'b0, 8'(8'hC0 + i));
        check("rstmid_count5", 32'(fifo_count), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("rstmid_async_count", 32'(fifo_count), 32'd0);
        check("rstmid_async_empty", {31'd0, fifo_empty}, 32'd1);
        check("rstmid_async_strobes", {30'd0, tx_valid, tx_break}, 32'd0);
        force_busy = 1'b0;
        #1;
        check("rstmid_idle", {31'd0, idle}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rstmid_count_after", 32'(fifo_count), 32'd0);
        check("rstmid_idle_after", {31'd0, idle}, 32'd1);
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/esp_uart_tx_fifo.md
# esp_uart_tx_fifo

Transmit-side buffer between the host write path and `esp_uart_tx`. Accepts bytes and break requests from the register interface into an in-order FIFO, then hands each entry to `esp_uart_tx` one at a time using its `tx_valid`/`tx_break`/`tx_busy` handshake. Exposes fill level, overflow and drain status so firmware can pace writes to the ESP link.

## Interface
- `DEPTH_LOG2`, 5, log2 of FIFO depth; depth = 2^DEPTH_LOG2 entries (default 32).
- `clk`  in  1  system clock, same clock as `esp_uart_tx`.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue `wr_data` this cycle.
- `wr_break`  in  1  enqueue a break entry this cycle. Takes priority over `wr_en`; `wr_data` is ignored when both are set.
- `overflow_clr`  in  1  clears `overflow`.
- `fifo_count`  out  DEPTH_LOG2+1  number of stored entries.
- `fifo_empty`  out  1  `fifo_count == 0`.
- `fifo_full`  out  1  `fifo_count == 2^DEPTH_LOG2`.
- `overflow`  out  1  sticky: a write was dropped.
- `idle`  out  1  FIFO empty, state IDLE, and `tx_busy` low.
- `tx_data`  out  8  byte to `esp_uart_tx`.
- `tx_valid`  out  1  one-cycle byte start strobe.
- `tx_break`  out  1  one-cycle break start strobe.
- `tx_busy`  in  1  from `esp_uart_tx`.

## Operation
- Storage is 2^DEPTH_LOG2 entries of 9 bits: bit 8 is the break marker and bits 7:0 are data. Storage uses read/write pointers of width DEPTH_LOG2 that wrap modulo the depth, plus a separate counter.
- Write qualification:
  - A write occurs when `wr_en|wr_break`.
  - The write is accepted if `fifo_count < depth`, or if a pop happens in the same cycle.
  - Otherwise the write is dropped and `overflow` is set on that edge.
  - `overflow_clr` clears `overflow`. If a dropped write and `overflow_clr` occur in the same cycle, the set wins.
- Count: a write alone adds 1, a pop alone subtracts 1, and a simultaneous write and pop leaves the count unchanged.
- Issue FSM:
  - IDLE: if `fifo_count != 0` and `!tx_busy`, pop the head entry and go to ISSUE. On the same edge, register the outputs:
    - `tx_break` = head[8]
    - `tx_valid` = !head[8]
    - `tx_data` = head[7:0], or 0 for a break entry
  - ISSUE (1 cycle): the strobe is high for exactly this cycle, during which `esp_uart_tx` samples it. Next state is HOLD, with the strobes cleared on the same edge.
  - HOLD (1 cycle): covers the one-cycle delay before `tx_busy` rises. `tx_busy` is ignored. Next state is WAIT.
  - WAIT: stay while `tx_busy`. When `tx_busy` is low, go to IDLE.
- `tx_data` holds its last value outside ISSUE.
- `tx_valid` and `tx_break` are never high together, and never high in two consecutive cycles.
- Entries are sent strictly in write order, so a break goes out between the bytes written before and after it.

## Timing
- Reset values: both pointers 0, `fifo_count` 0, `fifo_empty` 1, `fifo_full` 0, `overflow` 0, state IDLE, `tx_valid` 0, `tx_break` 0, `tx_data` 0, `idle` 1 (given `tx_busy` low).
- Reset is asynchronous and takes effect immediately. Asserting `rst` mid-transfer discards all queued entries and drops any strobe. `esp_uart_tx` shares `rst`, so both blocks restart clean.
- All status outputs are registered or derived from registered state. They change on the edge after the write or pop that causes the change.
- Latency from an empty, idle block: write on edge N, then `fifo_count` = 1 after N. The pop and strobe registration happen on edge N+1, so `tx_valid` is high between N+1 and N+2. `esp_uart_tx` starts on edge N+2.
- Minimum issue-to-issue spacing is 4 cycles (ISSUE, HOLD, WAIT, IDLE). In practice the spacing is set by `tx_busy`, which lasts about 80 clocks for a byte and about 128 clocks for a break.
- `idle` deasserts on the edge after an accepted write. It reasserts one cycle after `tx_busy` falls with the FIFO empty.

## Test plan
- Single byte:
  - Stimulus: write 0xA5 to an empty block.
  - Required response: `tx_valid` high for exactly 1 cycle, 2 cycles after the write, with `tx_data`=0xA5. `fifo_count` goes 1 then 0. `idle` returns to 1 after `tx_busy` falls.
- Burst:
  - Stimulus: write 0x01, 0x02, 0x03 on consecutive cycles.
  - Required response: `fifo_count` peaks at 3. Three `tx_valid` strobes in order 0x01, 0x02, 0x03. Each strobe follows a `tx_busy` fall and no strobe occurs while `tx_busy`=1.
- Ordered break:
  - Stimulus: write 0x11, then break, then 0x22 with `wr_en` and `wr_break` high together.
  - Required response: strobes occur in the order `tx_valid`(0x11), `tx_break`, `tx_break`. The last entry is a break because `wr_break` has priority.
- Overflow:
  - Stimulus: hold `tx_busy`=1, then write 33 bytes.
  - Required response: `fifo_full`=1 after the 32nd write. The 33rd write is dropped and `overflow`=1. `overflow_clr` clears it.
- Full with simultaneous pop:
  - Stimulus: with the FIFO full and `tx_busy` falling so a pop occurs, write 0x7E in the pop cycle.
  - Required response: the write is accepted, `fifo_count` stays 32, `overflow` stays 0, and 0x7E is sent last.
- Reset mid-operation:
  - Stimulus: with 5 entries queued and `tx_busy` high, pulse `rst`.
  - Required response: all outputs take their reset values asynchronously. No strobe follows after reset release until a new write.
